// File: rtl/mod_seq_div_pkg.sv
// Shared datapath constants and types for the FP multiplier/divider pair.
package mod_seq_div_pkg;

    // Mantissa datapath width shared with the Dadda multiplier.
    localparam int unsigned dadda_width = 12;

    // The divider works on the same mantissa width as the multiplier.
    localparam int unsigned div_width = dadda_width;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Signed partial remainder: one extra bit so the add/subtract never overflows.
    typedef logic [div_width:0] div_prem_t;

    // Iteration counter, counts WIDTH-1 down to 0.
    typedef logic [$clog2(div_width)-1:0] div_cnt_t;

endpackage

// File: rtl/mod_seq_div_step.sv
// One combinational radix-2 non-restoring division iteration.
module nr_div_step
    import mod_seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = div_width
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] p_sh;
    logic [WIDTH:0] d_ext;

    // Shift {P,Q} left, add or subtract D by the old sign of P, new Q bit is ~sign.
    always_comb begin
        p_sh   = {p[WIDTH-1:0], q[WIDTH-1]};
        d_ext  = {1'b0, d};
        p_next = p[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
        q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
    end

endmodule

// File: rtl/mod_seq_div.sv
// Sequential unsigned non-restoring divider, one quotient bit per cycle.
module mod_seq_div
    import mod_seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = div_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] p_fix;
    logic             accept;
    logic             last;
    logic             d_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (state == CALC) && (cnt == '0);
    assign d_zero    = (d_reg == '0);
    assign p_fix     = p_step[WIDTH-1:0] + d_reg;

    nr_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_step),
        .q_next (q_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode. A zero divisor passes through CALC for a single
    // cycle (counter loaded with 0) so its result lands one edge after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-cycle iteration and final remainder correction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            p_reg       <= '0;
            q_reg       <= dividend;
            d_reg       <= divisor;
            cnt         <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
            div_by_zero <= 1'b0;
        end else if (state == CALC) begin
            if (d_zero) begin
                quotient    <= '1;
                remainder   <= q_reg;
                div_by_zero <= 1'b1;
            end else begin
                p_reg <= p_step;
                q_reg <= q_step;
                cnt   <= cnt - CW'(1);
                if (last) begin
                    quotient  <= q_step;
                    remainder <= p_step[WIDTH] ? p_fix : p_step[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_seq_div.sv
// Self-checking bench for mod_seq_div with a result scoreboard.
module tb_mod_seq_div;

    localparam int W = 12;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mod_seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dbz = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare DUT outputs to the scoreboard head without popping it.
    task automatic cmp_front(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb[0];
            check({tag, "_quotient"}, int'(quotient), e.q);
            check({tag, "_remainder"}, int'(remainder), e.r);
            check({tag, "_dbz"}, int'(div_by_zero), e.dbz);
            if (e.dbz == 0) begin
                check({tag, "_qd_plus_r"}, int'(quotient) * e.b + int'(remainder), e.a);
                check({tag, "_r_lt_d"}, int'(int'(remainder) < e.b), 1);
            end
        end
    endtask

    // Handshake one operation; returns #1 after the accept edge.
    task automatic issue(input int a, input int b);
        @(negedge clk);
        check("issue_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Count edges after accept until out_valid rises (bounded).
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        check({tag, "_valid_low"}, int'(out_valid), 0);
        check({tag, "_ready_high"}, int'(in_ready), 1);
    endtask

    task automatic directed(input string tag, input int a, input int b, input int lat);
        sb.push_back(model(a, b));
        issue(a, b);
        wait_valid(tag, lat);
        cmp_front(tag);
        release_result(tag);
    endtask

    initial begin
        int  a;
        int  b;
        bit  done;

        // Reset values
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed operations: result visible cycle T+WIDTH+1 (T+2 for zero divisor)
        directed("d100_7", 100, 7, 12);
        directed("d4095_1", 4095, 1, 12);
        directed("d3_4095", 3, 4095, 12);
        directed("d5_0", 5, 0, 1);
        directed("d9_3", 9, 3, 12);

        // Backpressure with a stray second request
        sb.push_back(model(2730, 13));
        issue(2730, 13);
        wait_valid("bp", 12);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 3 && i < 8) begin
                in_valid = 1'b1;
                dividend = W'(1);
                divisor  = W'(1);
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            cmp_front("bp");
        end
        in_valid = 1'b0;
        release_result("bp");
        repeat (14) @(posedge clk);
        #1;
        check("bp_no_capture_valid", int'(out_valid), 0);
        check("bp_no_capture_ready", int'(in_ready), 1);

        // Asynchronous reset abort in the fifth CALC cycle
        issue(1000, 3);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_quotient", int'(quotient), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rel_out_valid", int'(out_valid), 0);
        check("abort_rel_in_ready", int'(in_ready), 1);
        directed("d50_6", 50, 6, 12);

        // Random sweep with random backpressure and ignored busy-time requests
        for (int n = 0; n < 3000; n++) begin
            a = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 15) == 0) b = 0;
            else if ($urandom_range(0, 3) == 0) b = int'($urandom_range(1, 15));
            else b = int'($urandom_range(1, 4095));
            sb.push_back(model(a, b));
            issue(a, b);
            done = 1'b0;
            for (int c = 0; c < 80 && !done; c++) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                dividend  = W'($urandom);
                divisor   = W'($urandom);
                if (out_valid) begin
                    cmp_front("rnd");
                    if (out_ready) begin
                        void'(sb.pop_front());
                        done = 1'b1;
                    end
                end
            end
            check("rnd_done", int'(done), 1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b0;
        end

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
